// File: rtl/fpu_mul_writeback_if.sv
// Handshake bundle between the FP32 multiplier, the writeback stage and its consumer.
interface fpu_mul_writeback_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic        in_error;
    logic        in_overflow;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_flags;

    // Producer/consumer side (drives results in, accepts retired entries)
    modport master (
        output in_valid, in_result, in_error, in_overflow, out_ready,
        input  in_ready, out_valid, out_result, out_flags
    );

    // Writeback stage side
    modport slave (
        input  in_valid, in_result, in_error, in_overflow, out_ready,
        output in_ready, out_valid, out_result, out_flags
    );
endinterface

// File: rtl/fpu_mul_writeback.sv
// Writeback/retire stage behind the combinational FP32 multiplier.
// Results are classified on capture, queued in a small FIFO, retired in order,
// and summarised in sticky exception flags plus a retired-operation counter.
module fpu_mul_writeback #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    fpu_mul_writeback_if.slave bus,
    input  logic             sticky_clear,
    output logic [4:0]       sticky_flags,
    output logic [CNT_W-1:0] op_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // Each slot holds {result, flags}; flags = {err, ovf, nan, inf, zero}
    logic [36:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, rd_next;
    logic [CW-1:0] count, count_next, remaining;
    logic          push, pop;
    logic [7:0]    in_exp;
    logic [22:0]   in_frac;
    logic [4:0]    in_flags;
    logic [31:0]   head_result;
    logic [4:0]    head_flags;
    logic [31:0]   head_result_next;
    logic [4:0]    head_flags_next;
    logic          in_ready_q;

    assign push = bus.in_valid & in_ready_q;
    assign pop  = bus.out_valid & bus.out_ready;

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = (count != '0);
    assign bus.out_result = head_result;
    assign bus.out_flags  = head_flags;

    // Classify the incoming result; the sign bit is ignored, denormals set no class flag
    always_comb begin
        in_exp   = bus.in_result[30:23];
        in_frac  = bus.in_result[22:0];
        in_flags = {bus.in_error,
                    bus.in_overflow,
                    (in_exp == 8'hFF) && (in_frac != '0),
                    (in_exp == 8'hFF) && (in_frac == '0),
                    (in_exp == 8'h00) && (in_frac == '0)};
    end

    // Occupancy after this edge, and the head the output registers should show next
    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
        remaining        = pop ? (count - 1'b1) : count;
        rd_next          = pop ? (rd_ptr + 1'b1) : rd_ptr;
        head_result_next = head_result;
        head_flags_next  = head_flags;
        if (remaining != '0) begin
            // An older entry becomes (or stays) the head
            {head_result_next, head_flags_next} = mem[rd_next];
        end else if (push) begin
            // Queue drains to empty this edge, so the new entry is the head
            head_result_next = bus.in_result;
            head_flags_next  = in_flags;
        end
    end

    // FIFO storage; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {bus.in_result, in_flags};
        end
    end

    // Pointers, occupancy, registered ready and head output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            in_ready_q  <= 1'b0;
            head_result <= '0;
            head_flags  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr      <= rd_next;
            count       <= count_next;
            in_ready_q  <= (count_next != FULL);
            head_result <= head_result_next;
            head_flags  <= head_flags_next;
        end
    end

    // Sticky exception flags (clear takes effect before the popped flags are OR-ed in) and retire counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sticky_flags <= '0;
            op_count     <= '0;
        end else begin
            if (pop) begin
                sticky_flags <= (sticky_clear ? 5'b00000 : sticky_flags) | head_flags;
                op_count     <= op_count + 1'b1;
            end else if (sticky_clear) begin
                sticky_flags <= '0;
            end
        end
    end
endmodule

// File: tb/tb_fpu_mul_writeback.sv
// Bench for fpu_mul_writeback: vector table for classification/retire, then multi-cycle sequences.
module tb_fpu_mul_writeback;
    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    logic             clk;
    logic             reset;
    logic             sticky_clear;
    logic [4:0]       sticky_flags;
    logic [CNT_W-1:0] op_count;

    fpu_mul_writeback_if bus ();

    fpu_mul_writeback #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus.slave),
        .sticky_clear (sticky_clear),
        .sticky_flags (sticky_flags),
        .op_count     (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] result;
        logic        err;
        logic        ovf;
        logic [4:0]  flags;
    } vec_t;

    vec_t vecs [9];
    int total = 0;
    int bad = 0;
    logic [4:0]       exp_sticky;
    logic [CNT_W-1:0] exp_op;
    logic [31:0]      q [$];
    logic [31:0]      held;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{32'h40C00000, 1'b0, 1'b0, 5'b00000};
        vecs[1] = '{32'h7FC00000, 1'b1, 1'b0, 5'b10100};
        vecs[2] = '{32'h7F800000, 1'b0, 1'b1, 5'b01010};
        vecs[3] = '{32'h80000000, 1'b0, 1'b0, 5'b00001};
        vecs[4] = '{32'h00000001, 1'b0, 1'b0, 5'b00000};
        vecs[5] = '{32'hFFFFFFFF, 1'b0, 1'b0, 5'b00100};
        vecs[6] = '{32'hFF800000, 1'b0, 1'b0, 5'b00010};
        vecs[7] = '{32'h3F800000, 1'b1, 1'b1, 5'b11000};
        vecs[8] = '{32'h00000000, 1'b0, 1'b0, 5'b00001};

        reset = 1'b1;
        sticky_clear = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_result = '0;
        bus.in_error = 1'b0;
        bus.in_overflow = 1'b0;
        bus.out_ready = 1'b0;
        #12;
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        chk("rst_out_result", bus.out_result, 0);
        chk("rst_out_flags", 32'(bus.out_flags), 0);
        chk("rst_sticky", 32'(sticky_flags), 0);
        chk("rst_op_count", 32'(op_count), 0);
        @(negedge clk);
        reset = 1'b0;
        tick;
        chk("rst_in_ready_rise", 32'(bus.in_ready), 1);

        // Table: push one, check head and flags, pop it, check counters
        exp_sticky = '0;
        exp_op = '0;
        for (int i = 0; i < 9; i++) begin
            bus.in_valid = 1'b1;
            bus.in_result = vecs[i].result;
            bus.in_error = vecs[i].err;
            bus.in_overflow = vecs[i].ovf;
            tick;
            bus.in_valid = 1'b0;
            chk($sformatf("v%0d_out_valid", i), 32'(bus.out_valid), 1);
            chk($sformatf("v%0d_out_result", i), bus.out_result, vecs[i].result);
            chk($sformatf("v%0d_out_flags", i), 32'(bus.out_flags), 32'(vecs[i].flags));
            bus.out_ready = 1'b1;
            tick;
            bus.out_ready = 1'b0;
            exp_op = exp_op + 1'b1;
            exp_sticky = exp_sticky | vecs[i].flags;
            chk($sformatf("v%0d_op_count", i), 32'(op_count), 32'(exp_op));
            chk($sformatf("v%0d_sticky", i), 32'(sticky_flags), 32'(exp_sticky));
            chk($sformatf("v%0d_drained", i), 32'(bus.out_valid), 0);
            chk($sformatf("v%0d_result_held", i), bus.out_result, vecs[i].result);
        end
        chk("table_sticky_all", 32'(sticky_flags), 32'h1F);

        // Sticky clear coinciding with a pop keeps only the popped flags
        bus.in_valid = 1'b1;
        bus.in_result = 32'h7F800000;
        bus.in_error = 1'b0;
        bus.in_overflow = 1'b0;
        tick;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        sticky_clear = 1'b1;
        tick;
        bus.out_ready = 1'b0;
        exp_op = exp_op + 1'b1;
        chk("clr_pop_sticky", 32'(sticky_flags), 32'h02);
        chk("clr_pop_op_count", 32'(op_count), 32'(exp_op));
        tick;
        sticky_clear = 1'b0;
        chk("clr_only_sticky", 32'(sticky_flags), 0);
        chk("clr_only_op_count", 32'(op_count), 32'(exp_op));

        // Reset in the middle of a cycle with three queued entries
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_result = 32'h41000000 + 32'(i);
            tick;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        sticky_clear = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(bus.out_valid), 0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 0);
        chk("mid_rst_sticky", 32'(sticky_flags), 0);
        chk("mid_rst_op_count", 32'(op_count), 0);
        chk("mid_rst_out_result", bus.out_result, 0);
        tick;
        bus.out_ready = 1'b0;
        #1;
        reset = 1'b0;
        chk("rel_in_ready_low", 32'(bus.in_ready), 0);
        tick;
        chk("rel_in_ready_high", 32'(bus.in_ready), 1);
        chk("rel_out_valid", 32'(bus.out_valid), 0);

        // Two queued, then sixteen cycles of push+pop: order kept, counter wraps to 0
        exp_op = '0;
        q.delete();
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            bus.in_result = 32'h3F000000 + 32'(i);
            q.push_back(bus.in_result);
            tick;
        end
        chk("wrap_head0", bus.out_result, q[0]);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.in_result = 32'h3F000100 + 32'(i);
            q.push_back(bus.in_result);
            void'(q.pop_front());
            exp_op = exp_op + 1'b1;
            tick;
            chk($sformatf("wrap%0d_head", i), bus.out_result, q[0]);
            chk($sformatf("wrap%0d_op_count", i), 32'(op_count), 32'(exp_op));
            chk($sformatf("wrap%0d_in_ready", i), 32'(bus.in_ready), 1);
        end
        chk("wrap_op_count_end", 32'(op_count), 0);
        bus.in_valid = 1'b0;
        void'(q.pop_front());
        tick;
        chk("wrap_drain_head", bus.out_result, q[0]);
        chk("wrap_drain_valid", 32'(bus.out_valid), 1);
        tick;
        bus.out_ready = 1'b0;
        chk("wrap_drain_empty", 32'(bus.out_valid), 0);

        // Fill to full with back-to-back pushes; fifth is refused, even during the first pop
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_result = 32'h40000000 + 32'(i << 4);
            tick;
            chk($sformatf("fill%0d_in_ready", i), 32'(bus.in_ready), (i < 3) ? 1 : 0);
        end
        chk("full_head_hold", bus.out_result, 32'h40000000);
        bus.in_result = 32'hDEADBEEF;
        bus.out_ready = 1'b1;
        tick;
        bus.in_valid = 1'b0;
        chk("full_pop_in_ready", 32'(bus.in_ready), 1);
        chk("full_pop_head1", bus.out_result, 32'h40000010);
        held = 32'h40000010;
        for (int i = 2; i < 4; i++) begin
            tick;
            held = 32'h40000000 + 32'(i << 4);
            chk($sformatf("full_pop_head%0d", i), bus.out_result, held);
        end
        tick;
        bus.out_ready = 1'b0;
        chk("full_drained", 32'(bus.out_valid), 0);
        chk("full_last_held", bus.out_result, held);
        chk("full_op_count", 32'(op_count), 32'((18 + 4) % 16));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
